// File: rtl/single_cycle_risc_pkg.sv
// rtl/single_cycle_risc_pkg.sv - shared opcodes, function codes, condition codes and field positions
package single_cycle_risc_pkg;

    // Major opcodes, instruction[15:11]
    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LHI = 5'b00001;
    localparam logic [4:0] OP_LLI = 5'b00010;
    localparam logic [4:0] OP_LDR = 5'b00011;
    localparam logic [4:0] OP_STR = 5'b00101;
    localparam logic [4:0] OP_CMP = 5'b00110;
    localparam logic [4:0] OP_BCC = 5'b11000;
    localparam logic [4:0] OP_SYS = 5'b11100;

    // ALU function codes, instruction[1:0]
    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_ADC = 2'b01;
    localparam logic [1:0] FN_SUB = 2'b10;
    localparam logic [1:0] FN_SBB = 2'b11;

    // CMP and system function codes
    localparam logic [1:0] FN_CMP = 2'b01;
    localparam logic [1:0] FN_OUT = 2'b00;
    localparam logic [1:0] FN_HLT = 2'b01;

    // Branch conditions, carried in the Rd field
    localparam logic [2:0] CC_EQ = 3'b000;
    localparam logic [2:0] CC_NE = 3'b001;
    localparam logic [2:0] CC_LT = 3'b010;
    localparam logic [2:0] CC_GE = 3'b011;
    localparam logic [2:0] CC_LO = 3'b100;
    localparam logic [2:0] CC_HS = 3'b101;
    localparam logic [2:0] CC_AL = 3'b110;
    localparam logic [2:0] CC_NV = 3'b111;

    // Instruction field positions
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 11;
    localparam int RD_MSB = 10;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 5;
    localparam int RT_MSB = 4;
    localparam int RT_LSB = 2;

    function automatic logic cond_met(input logic [2:0] cc, input logic c, input logic z,
                                      input logic n, input logic v);
        logic taken;
        case (cc)
            CC_EQ:   taken = z;
            CC_NE:   taken = !z;
            CC_LT:   taken = n ^ v;
            CC_GE:   taken = !(n ^ v);
            CC_LO:   taken = !c;
            CC_HS:   taken = c;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/single_cycle_risc_alu.sv
// rtl/single_cycle_risc_alu.sv - combinational add/subtract unit with C/Z/N/V flags
//
// Ports:
//   op, fn       opcode and function code of the current instruction
//   a, b, c_in   Rs value, Rt value, current carry flag
//   result       16-bit result
//   c_out..v_out new carry (no-borrow for subtract), zero, negative, overflow
module single_cycle_risc_alu
    import single_cycle_risc_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [1:0]  fn,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] result,
    output logic        c_out,
    output logic        z_out,
    output logic        n_out,
    output logic        v_out
);

    logic        is_sub;
    logic        use_carry;
    logic        cin;
    logic [15:0] b_eff;
    logic [16:0] sum;

    // Subtract is a + ~b + 1; subtract-with-borrow is a + ~b + C, so the
    // adder carry out doubles as the no-borrow flag. CMP is always a plain SUB.
    always_comb begin
        is_sub    = (op == OP_CMP) || fn[1];
        use_carry = (op != OP_CMP) && fn[0];
        b_eff     = is_sub ? ~b : b;
        cin       = use_carry ? c_in : is_sub;
        sum       = {1'b0, a} + {1'b0, b_eff} + {16'd0, cin};
        result    = sum[15:0];
        c_out     = sum[16];
        z_out     = (sum[15:0] == 16'd0);
        n_out     = sum[15];
        v_out     = (a[15] == b_eff[15]) && (sum[15] != a[15]);
    end

endmodule

// File: rtl/single_cycle_risc.sv
// rtl/single_cycle_risc.sv - 16-bit single-cycle RISC core with private instruction and data memories
//
// Ports:
//   clk, clr                         clock, synchronous active-high reset
//   test_normal                      1 = core frozen, loader writes enabled
//   ext_instr_we/addr/data           instruction-memory loader write port
//   ext_data_we/addr/data            data-memory loader write port
//   OutR                             value latched by the last OUT
//   done                             set by HLT
//   instruction                      Imem[PC], combinational
module single_cycle_risc
    import single_cycle_risc_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        test_normal,
    input  logic        ext_instr_we,
    input  logic [15:0] ext_instr_addr,
    input  logic [15:0] ext_instr_data,
    input  logic        ext_data_we,
    input  logic [15:0] ext_data_addr,
    input  logic [15:0] ext_data_data,
    output logic [15:0] OutR,
    output logic        done,
    output logic [15:0] instruction
);

    localparam int DEPTH = 1 << AW;

    logic [15:0] imem [DEPTH];
    logic [15:0] dmem [DEPTH];
    logic [15:0] regs [8];

    logic [15:0] pc;
    logic        c_flag, z_flag, n_flag, v_flag;
    logic [15:0] out_r;
    logic        done_r;

    logic [4:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [1:0]  fn;
    logic [7:0]  imm8;
    logic [4:0]  imm5;
    logic [15:0] rd_val, rs_val, rt_val;
    logic [15:0] mem_addr, load_data;

    logic [15:0] alu_result;
    logic        alu_c, alu_z, alu_n, alu_v;

    logic        run;
    logic        reg_we, flags_we, dmem_we, out_we, halt, branch;
    logic [15:0] reg_wdata;
    logic [15:0] pc_next;

    // Upper address bits are ignored: memories only decode the low AW bits.
    logic unused_bits;
    assign unused_bits = ^{pc[15:AW], mem_addr[15:AW], ext_instr_addr[15:AW], ext_data_addr[15:AW]};

    assign instruction = imem[pc[AW-1:0]];
    assign op          = instruction[OP_MSB:OP_LSB];
    assign rd          = instruction[RD_MSB:RD_LSB];
    assign rs          = instruction[RS_MSB:RS_LSB];
    assign rt          = instruction[RT_MSB:RT_LSB];
    assign fn          = instruction[1:0];
    assign imm8        = instruction[7:0];
    assign imm5        = instruction[4:0];

    assign rd_val    = regs[rd];
    assign rs_val    = regs[rs];
    assign rt_val    = regs[rt];
    assign mem_addr  = rs_val + {11'd0, imm5};
    assign load_data = dmem[mem_addr[AW-1:0]];

    assign run  = !test_normal && !done_r;
    assign OutR = out_r;
    assign done = done_r;

    single_cycle_risc_alu u_alu (
        .op     (op),
        .fn     (fn),
        .a      (rs_val),
        .b      (rt_val),
        .c_in   (c_flag),
        .result (alu_result),
        .c_out  (alu_c),
        .z_out  (alu_z),
        .n_out  (alu_n),
        .v_out  (alu_v)
    );

    always_comb begin
        reg_we    = 1'b0;
        reg_wdata = alu_result;
        flags_we  = 1'b0;
        dmem_we   = 1'b0;
        out_we    = 1'b0;
        halt      = 1'b0;
        branch    = 1'b0;
        case (op)
            OP_LHI: begin
                reg_we    = 1'b1;
                reg_wdata = {imm8, rd_val[7:0]};
            end
            OP_LLI: begin
                reg_we    = 1'b1;
                reg_wdata = {8'h00, imm8};
            end
            OP_LDR: begin
                reg_we    = 1'b1;
                reg_wdata = load_data;
            end
            OP_STR: dmem_we = 1'b1;
            OP_ALU: begin
                reg_we   = 1'b1;
                flags_we = 1'b1;
            end
            OP_CMP: flags_we = (fn == FN_CMP);
            OP_BCC: branch = cond_met(rd, c_flag, z_flag, n_flag, v_flag);
            OP_SYS: begin
                out_we = (fn == FN_OUT);
                halt   = (fn == FN_HLT);
            end
            default: ;
        endcase

        if (branch) begin
            pc_next = pc + 16'd1 + {{8{imm8[7]}}, imm8};
        end else if (halt) begin
            pc_next = pc;
        end else begin
            pc_next = pc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc     <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            v_flag <= 1'b0;
            out_r  <= '0;
            done_r <= 1'b0;
        end else if (run) begin
            pc <= pc_next;
            if (reg_we) begin
                regs[rd] <= reg_wdata;
            end
            if (flags_we) begin
                c_flag <= alu_c;
                z_flag <= alu_z;
                n_flag <= alu_n;
                v_flag <= alu_v;
            end
            if (out_we) begin
                out_r <= rs_val;
            end
            if (halt) begin
                done_r <= 1'b1;
            end
        end
    end

    // Memories are never cleared; clr only blocks a store from the core.
    always_ff @(posedge clk) begin
        if (test_normal && ext_instr_we) begin
            imem[ext_instr_addr[AW-1:0]] <= ext_instr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (test_normal) begin
            if (ext_data_we) begin
                dmem[ext_data_addr[AW-1:0]] <= ext_data_data;
            end
        end else if (!clr && run && dmem_we) begin
            dmem[mem_addr[AW-1:0]] <= rd_val;
        end
    end

endmodule

// File: tb/tb_single_cycle_risc.sv
// tb/tb_single_cycle_risc.sv - self-checking bench with behavioural model for single_cycle_risc
module tb_single_cycle_risc;

    logic        clk = 1'b0;
    logic        clr, test_normal, ext_instr_we, ext_data_we;
    logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
    logic [15:0] OutR, instruction;
    logic        done;

    always #5 clk = ~clk;

    single_cycle_risc #(.AW(8)) dut (
        .clk            (clk),
        .clr            (clr),
        .test_normal    (test_normal),
        .ext_instr_we   (ext_instr_we),
        .ext_instr_addr (ext_instr_addr),
        .ext_instr_data (ext_instr_data),
        .ext_data_we    (ext_data_we),
        .ext_data_addr  (ext_data_addr),
        .ext_data_data  (ext_data_data),
        .OutR           (OutR),
        .done           (done),
        .instruction    (instruction)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    logic [15:0] m_r [8];
    logic [15:0] m_pc, m_out;
    logic        m_c, m_z, m_n, m_v, m_done;

    logic [15:0] prog [$];
    logic [15:0] seen [$];
    logic [15:0] exp_seq [5] = '{16'h6325, 16'h0047, 16'h0089, 16'h00D0, 16'hFFBE};

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt, input int fn);
        return {5'(op), 3'(rd), 3'(rs), 3'(rt), 2'(fn)};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int imm8);
        return {5'(op), 3'(rd), 8'(imm8)};
    endfunction

    function automatic logic [15:0] enc_m(input int op, input int rd, input int rs, input int imm5);
        return {5'(op), 3'(rd), 3'(rs), 5'(imm5)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: one call per rising edge, using the inputs held across it.
    task automatic model_step();
        logic [15:0] w, r16, nxt;
        logic [4:0]  op;
        logic [2:0]  rd, rs, rt;
        logic [1:0]  fn, afn;
        int a, b, sa, sb, t, st, brw, cin, off;
        bit take;
        if (test_normal && ext_instr_we) m_imem[ext_instr_addr[7:0]] = ext_instr_data;
        if (test_normal && ext_data_we)  m_dmem[ext_data_addr[7:0]]  = ext_data_data;
        if (clr) begin
            m_pc = 0; m_out = 0; m_done = 0;
            m_c = 0; m_z = 0; m_n = 0; m_v = 0;
            for (int i = 0; i < 8; i++) m_r[i] = 0;
        end else if (!test_normal && !m_done) begin
            w  = m_imem[m_pc[7:0]];
            op = w[15:11]; rd = w[10:8]; rs = w[7:5]; rt = w[4:2]; fn = w[1:0];
            a  = int'(m_r[rs]);
            b  = int'(m_r[rt]);
            sa = int'($signed(m_r[rs]));
            sb = int'($signed(m_r[rt]));
            nxt = m_pc + 16'd1;
            case (op)
                5'd1: m_r[rd] = {w[7:0], m_r[rd][7:0]};
                5'd2: m_r[rd] = {8'h00, w[7:0]};
                5'd3: m_r[rd] = m_dmem[(a + int'(w[4:0])) % 256];
                5'd5: m_dmem[(a + int'(w[4:0])) % 256] = m_r[rd];
                5'd0, 5'd6: begin
                    if (op == 5'd0 || fn == 2'd1) begin
                        afn = (op == 5'd6) ? 2'd2 : fn;
                        brw = (afn == 2'd3 && !m_c) ? 1 : 0;
                        cin = (afn == 2'd1 && m_c) ? 1 : 0;
                        if (afn[1]) begin
                            t = a - b - brw; st = sa - sb - brw; m_c = (t >= 0);
                        end else begin
                            t = a + b + cin; st = sa + sb + cin; m_c = (t > 65535);
                        end
                        r16 = t[15:0];
                        m_v = (st > 32767) || (st < -32768);
                        m_z = (r16 == 16'd0);
                        m_n = r16[15];
                        if (op == 5'd0) m_r[rd] = r16;
                    end
                end
                5'd24: begin
                    case (rd)
                        3'd0: take = m_z;
                        3'd1: take = !m_z;
                        3'd2: take = (m_n != m_v);
                        3'd3: take = (m_n == m_v);
                        3'd4: take = !m_c;
                        3'd5: take = m_c;
                        3'd6: take = 1;
                        default: take = 0;
                    endcase
                    if (take) begin
                        off = int'($signed(w[7:0]));
                        nxt = 16'(int'(m_pc) + 1 + off);
                    end
                end
                5'd28: begin
                    if (fn == 2'd0) m_out = m_r[rs];
                    else if (fn == 2'd1) begin m_done = 1; nxt = m_pc; end
                end
                default: ;
            endcase
            m_pc = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) begin
            chk("outr", OutR, m_out);
            chk("done", {15'd0, done}, {15'd0, m_done});
            chk("instruction", instruction, m_imem[m_pc[7:0]]);
        end
    endtask

    task automatic idle_inputs();
        clr = 0; test_normal = 0; ext_instr_we = 0; ext_data_we = 0;
    endtask

    task automatic load_prog();
        test_normal = 1;
        for (int i = 0; i < prog.size(); i++) begin
            ext_instr_we = 1; ext_instr_addr = 16'(i); ext_instr_data = prog[i];
            tick();
        end
        ext_instr_we = 0; clr = 1;
        tick();
        idle_inputs();
    endtask

    task automatic run_until_done(input int budget);
        logic [15:0] last;
        int n;
        last = OutR; n = 0;
        seen.delete();
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
            if (OutR !== last) begin
                seen.push_back(OutR);
                last = OutR;
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout done=%b required 1", done);
        end
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, 16'(seen.size()), 16'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_%0d", name, i), (i < seen.size()) ? seen[i] : 16'hXXXX, exp_seq[i]);
        end
    endtask

    task automatic run_directed(input string name, input logic [15:0] exp_out);
        load_prog();
        run_until_done(100);
        chk(name, OutR, exp_out);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        int ops [9] = '{0, 1, 2, 3, 5, 6, 24, 28, 0};
        int pick;
        w = 16'($urandom);
        pick = $urandom_range(0, 8);
        if (pick == 8) ops[8] = $urandom_range(0, 31);
        w[15:11] = 5'(ops[pick]);
        if (ops[pick] == 24) w[7:0] = 8'($urandom_range(0, 8) - 4);
        if (ops[pick] == 28 && w[1:0] == 2'd1 && $urandom_range(0, 7) != 0) w[1:0] = 2'd0;
        return w;
    endfunction

    initial begin
        clr = 1; test_normal = 1; ext_instr_we = 0; ext_data_we = 0;
        ext_instr_addr = 0; ext_instr_data = 0; ext_data_addr = 0; ext_data_data = 0;

        // Zero both memories so the model and DUT start from known contents.
        for (int i = 0; i < 256; i++) begin
            ext_instr_we = 1; ext_data_we = 1;
            ext_instr_addr = 16'(i); ext_data_addr = 16'(i);
            ext_instr_data = 0; ext_data_data = 0;
            tick();
        end
        ext_instr_we = 0; ext_data_we = 0;
        tick();
        chk_en = 1;
        idle_inputs();
        chk("reset_outr", OutR, 16'h0000);
        chk("reset_done", {15'd0, done}, 16'h0000);
        chk("reset_instr", instruction, 16'h0000);

        // Reference program; data addresses carry junk upper bits to exercise truncation.
        test_normal = 1; ext_data_we = 1;
        ext_data_addr = 16'hAB25; ext_data_data = 16'h0047; tick();
        ext_data_addr = 16'h1226; ext_data_data = 16'h0089; tick();
        ext_data_we = 0;
        prog = '{16'h1025, 16'h0863, 16'hE000, 16'h1900, 16'h1A01, 16'hE020,
                 16'hE040, 16'h0328, 16'hE060, 16'h032A, 16'hE060, 16'hE001};
        load_prog();
        run_until_done(40);
        check_seq("prog_seq");
        for (int i = 0; i < 5; i++) tick();
        chk("halt_done", {15'd0, done}, 16'h0001);
        chk("halt_outr", OutR, 16'hFFBE);
        chk("halt_instr", instruction, 16'hE001);

        // Reset mid-program, then rerun
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 5; i++) tick();
        clr = 1; tick(); clr = 0;
        chk("mid_rst_outr", OutR, 16'h0000);
        chk("mid_rst_done", {15'd0, done}, 16'h0000);
        chk("mid_rst_instr", instruction, 16'h1025);
        run_until_done(40);
        check_seq("rerun_seq");

        // Test-mode freeze after three instructions
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_freeze_outr", OutR, 16'h6325);
        test_normal = 1;
        for (int i = 0; i < 10; i++) tick();
        chk("freeze_outr", OutR, 16'h6325);
        chk("freeze_instr", instruction, 16'h1900);
        test_normal = 0;
        run_until_done(40);
        chk("post_freeze_outr", OutR, 16'hFFBE);

        // STR/LDR round trip
        prog = '{enc_i(2, 1, 8'hAA), enc_m(5, 1, 0, 3), enc_m(3, 2, 0, 3),
                 enc_r(28, 0, 2, 0, 0), enc_r(28, 0, 0, 0, 1)};
        run_directed("str_ldr", 16'h00AA);

        // CMP + BLO minimum select, both operand orders
        for (int sw = 0; sw < 2; sw++) begin
            prog = '{enc_i(2, 1, sw ? 8'h89 : 8'h47), enc_i(2, 2, sw ? 8'h47 : 8'h89),
                     enc_r(6, 0, 1, 2, 1), enc_i(24, 4, 2),
                     enc_r(28, 0, 2, 0, 0), enc_r(28, 0, 0, 0, 1),
                     enc_r(28, 0, 1, 0, 0), enc_r(28, 0, 0, 0, 1)};
            run_directed(sw ? "cmp_min_swapped" : "cmp_min", 16'h0047);
        end

        // ADD 7FFF+1: N=1,V=1 so BLT must fall through
        prog = '{enc_i(2, 1, 8'hFF), enc_i(1, 1, 8'h7F), enc_i(2, 2, 8'h01),
                 enc_r(0, 3, 1, 2, 0), enc_i(24, 2, 2),
                 enc_r(28, 0, 3, 0, 0), enc_r(28, 0, 0, 0, 1),
                 enc_i(2, 4, 8'hEE), enc_r(28, 0, 4, 0, 0), enc_r(28, 0, 0, 0, 1)};
        run_directed("add_overflow", 16'h8000);

        // SUB 5-5: Z=1 and C=1 both required to reach OUT 77h
        prog = '{enc_i(2, 1, 5), enc_i(2, 2, 5), enc_r(0, 3, 1, 2, 2),
                 enc_i(24, 0, 2), enc_r(28, 0, 1, 0, 0), enc_r(28, 0, 0, 0, 1),
                 enc_i(24, 5, 2), enc_r(28, 0, 2, 0, 0), enc_r(28, 0, 0, 0, 1),
                 enc_i(2, 4, 8'h77), enc_r(28, 0, 4, 0, 0), enc_r(28, 0, 0, 0, 1)};
        run_directed("sub_zero_carry", 16'h0077);

        // ADC after FFFF+1 carry: 10h+20h+1
        prog = '{enc_i(2, 1, 8'hFF), enc_i(1, 1, 8'hFF), enc_i(2, 2, 1),
                 enc_r(0, 3, 1, 2, 0), enc_i(2, 5, 8'h10), enc_i(2, 6, 8'h20),
                 enc_r(0, 7, 5, 6, 1), enc_r(28, 0, 7, 0, 0), enc_r(28, 0, 0, 0, 1)};
        run_directed("adc_carry", 16'h0031);

        // Randomized programs, loader traffic and resets, checked against the model
        for (int it = 0; it < 6; it++) begin
            test_normal = 1;
            for (int i = 0; i < 32; i++) begin
                ext_instr_we = 1; ext_data_we = 1;
                ext_instr_addr = {8'($urandom), 8'(i)};
                ext_data_addr  = {8'($urandom), 8'(i)};
                ext_instr_data = rand_instr();
                ext_data_data  = 16'($urandom);
                tick();
            end
            ext_instr_we = 0; ext_data_we = 0; clr = 1;
            tick();
            idle_inputs();
            for (int c = 0; c < 150; c++) begin
                int r;
                r = $urandom_range(0, 99);
                clr = (r == 0);
                test_normal = (r >= 95);
                if (test_normal) begin
                    ext_instr_we = 1'($urandom); ext_data_we = 1'($urandom);
                    ext_instr_addr = 16'($urandom); ext_data_addr = 16'($urandom);
                    ext_instr_data = rand_instr(); ext_data_data = 16'($urandom);
                end
                tick();
                idle_inputs();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
